// File: rtl/uart_monitor_pkg.sv
// Shared types for the passive UART receive monitor.
package uart_monitor_pkg;

  localparam int UART_ERR_W = 3;

  // Per-frame error flags, ordered {break, framing, parity}.
  typedef struct packed {
    logic brk;
    logic framing;
    logic parity;
  } uart_frame_err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_frame_fifo.sv
// Show-ahead frame buffer with a sticky overflow flag.
module uart_frame_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Pointers, occupancy and the sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      // A fresh drop wins over a clear in the same cycle.
      overflow <= (overflow && !overflow_clr) || drop;
    end
  end

  // Frame storage write port.
  // NOTE: storage is not reset; the head output is masked while empty, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_frame_monitor.sv
// Passive UART receive monitor: synchronise, oversample, reassemble and buffer frames.
module uart_rx_frame_monitor
  import uart_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   baud_div,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic                          frame_valid,
  output logic [DATA_WIDTH-1:0]         frame_data,
  output logic [UART_ERR_W-1:0]         frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int              SCW       = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0]  SAMP_MID  = SCW'(OVERSAMPLE/2 - 1);
  localparam logic [SCW-1:0]  SAMP_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            PAR_EN    = (PARITY_EN != 0);
  localparam logic            ODD_PAR   = (PARITY_ODD != 0);
  localparam int              FW        = UART_ERR_W + DATA_WIDTH;

  uart_rx_state_e          state, state_nxt;
  logic                    rx_meta, rx_sync, rx_prev;
  logic [15:0]             div_cnt, div_max_q, div_max_in;
  logic                    tick;
  logic [SCW-1:0]          samp_cnt;
  logic [3:0]              bit_cnt;
  logic                    bit_end;
  logic                    start_det, do_shift, do_par, do_stop, frame_done;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_bit_q;
  uart_frame_err_t         err_q;
  logic                    wait_high;
  logic                    done_q, push_q;
  logic [FW-1:0]           push_word, head;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idle line is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Divisor is re-latched only at start and at each wrap, so mid-frame changes apply at the next wrap.
  assign div_max_in = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign tick       = (state != ST_IDLE) && (div_cnt == div_max_q);
  assign bit_end    = tick && (samp_cnt == SAMP_LAST);

  // Oversample tick generator, idle outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      div_max_q <= '0;
    end else if (start_det || tick) begin
      div_cnt   <= '0;
      div_max_q <= div_max_in;
    end else if (state == ST_IDLE) begin
      div_cnt   <= '0;
    end else begin
      div_cnt   <= div_cnt + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-sample strobes for the datapath.
  // NOTE: every output gets a default up front so no path through the case infers a latch.
  always_comb begin
    state_nxt  = state;
    start_det  = 1'b0;
    do_shift   = 1'b0;
    do_par     = 1'b0;
    do_stop    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!wait_high && !rx_sync && rx_prev) begin
          start_det = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick && samp_cnt == SAMP_MID) state_nxt = rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          do_shift = 1'b1;
          if (bit_cnt == DATA_LAST) state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          do_par    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          do_stop = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sample/bit counters and frame assembly; the finished frame is pushed two cycles after the last stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      err_q     <= '0;
      wait_high <= 1'b0;
      done_q    <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      if (state == ST_IDLE) samp_cnt <= '0;
      else if (tick)        samp_cnt <= (state_nxt != state || samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SCW'(1);

      if (state_nxt != state)       bit_cnt <= '0;
      else if (do_shift || do_stop) bit_cnt <= bit_cnt + 4'd1;

      if (start_det) begin
        par_bit_q <= 1'b0;
        err_q     <= '0;
      end
      if (do_shift) shift_q <= {rx_sync, shift_q[DATA_WIDTH-1:1]};
      if (do_par) begin
        par_bit_q    <= rx_sync;
        err_q.parity <= ((^shift_q) ^ rx_sync) != ODD_PAR;
      end
      if (do_stop) begin
        if (!rx_sync)        err_q.framing <= 1'b1;
        if (bit_cnt == 4'd0) err_q.brk     <= (shift_q == '0) && !par_bit_q && !rx_sync;
      end

      // A low stop bit keeps start detection disarmed until the line returns high.
      if (frame_done) wait_high <= !rx_sync;
      else if (rx_sync) wait_high <= 1'b0;

      done_q <= frame_done;
      push_q <= done_q;
      if (done_q) push_word <= {err_q, shift_q};
    end
  end

  uart_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push_q),
    .push_data    (push_word),
    .pop          (rd_en),
    .head         (head),
    .valid        (frame_valid),
    .count        (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  assign frame_data = head[DATA_WIDTH-1:0];
  assign frame_err  = head[FW-1:DATA_WIDTH];

endmodule

// File: tb/tb_uart_rx_frame_monitor.sv
// Directed bench for uart_rx_frame_monitor at default parameters.
module tb_uart_rx_frame_monitor;

  localparam int DW = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        rx;
  logic        rd_en;
  logic        frame_valid;
  logic [7:0]  frame_data;
  logic [2:0]  frame_err;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        overflow_clr;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_frame_monitor #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16),
    .PARITY_EN  (1),
    .PARITY_ODD (0),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_div     (baud_div),
    .rx           (rx),
    .rd_en        (rd_en),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .frame_err    (frame_err),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [15:0] bd;
    logic [2:0]  err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame; the final stop sample lands 3+8*bd edges after the stop bit is driven.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic [15:0] bd, input bit pop_at_push,
                            input bit clr_at_push, input bit check_lat);
    int bc;
    bc = 16 * ((bd == 16'd0) ? 1 : int'(bd));
    baud_div = bd;
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < DW; i++) begin
      repeat (bc) @(posedge clk);
      #1 rx = data[i];
    end
    repeat (bc) @(posedge clk); #1 rx = par;
    repeat (bc) @(posedge clk); #1 rx = stop;
    repeat (3 + bc/2) @(posedge clk);
    @(posedge clk); #1;
    rd_en        = pop_at_push;
    overflow_clr = clr_at_push;
    if (check_lat) begin
      @(negedge clk);
      check("latency_plus1_valid", frame_valid, 0);
    end
    @(posedge clk); #1;
    rd_en        = 1'b0;
    overflow_clr = 1'b0;
    if (check_lat) begin
      @(negedge clk);
      check("latency_plus2_valid", frame_valid, 1);
    end
    rx = 1'b1;
    repeat (bc) @(posedge clk);
    #1;
  endtask

  task automatic pop_head();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_head(input string name, input logic [7:0] data, input logic [2:0] err);
    @(negedge clk);
    check({name, "_data"}, frame_data, data);
    check({name, "_err"}, frame_err, err);
  endtask

  initial begin
    logic [7:0] d;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 16'd1, 3'b000};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 16'd1, 3'b001};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 16'd1, 3'b110};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 16'd2, 3'b000};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 16'd0, 3'b001};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 16'd1, 3'b000};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 16'd1, 3'b011};
    vecs[7] = '{8'h00, 1'b0, 1'b1, 16'd3, 3'b000};

    rx = 1'b1; rd_en = 1'b0; overflow_clr = 1'b0; baud_div = 16'd1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("reset_valid", frame_valid, 0);
    check("reset_data", frame_data, 0);
    check("reset_err", frame_err, 0);
    check("reset_count", fifo_count, 0);
    check("reset_overflow", overflow, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Table-driven single frames, each into an empty FIFO.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].bd, 1'b0, 1'b0, 1'b1);
      expect_head($sformatf("vec%0d", i), vecs[i].data, vecs[i].err);
      check($sformatf("vec%0d_count", i), fifo_count, 1);
      pop_head();
      check($sformatf("vec%0d_count_after_pop", i), fifo_count, 0);
    end

    // Start glitch: four clocks low then high before the start-bit centre.
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_count", fifo_count, 0);
    check("glitch_valid", frame_valid, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1);
    expect_head("after_glitch", 8'h5A, 3'b000);
    pop_head();

    // Five frames into a depth-4 FIFO: fifth dropped, overflow sticks.
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, ^d, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      expect_head($sformatf("ovf_pop%0d", i), 8'(i), 3'b000);
      pop_head();
    end
    check("ovf_drained_count", fifo_count, 0);
    check("ovf_rd_empty_keeps_flag", overflow, 1);
    pop_head();
    check("rd_while_empty_count", fifo_count, 0);
    @(posedge clk); #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);

    // Full FIFO with a pop in the push cycle: nothing dropped.
    for (int i = 1; i <= 4; i++) begin
      d = 8'h10 + 8'(i);
      send_frame(d, ^d, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    end
    send_frame(8'h55, 1'b0, 1'b1, 16'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("full_pop_push_count", fifo_count, 4);
    check("full_pop_push_overflow", overflow, 0);
    // Drop with a simultaneous clear: the new overflow wins.
    send_frame(8'h66, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("clr_vs_drop_overflow", overflow, 1);
    check("clr_vs_drop_count", fifo_count, 4);
    expect_head("fpp_pop1", 8'h12, 3'b000); pop_head();
    expect_head("fpp_pop2", 8'h13, 3'b000); pop_head();
    expect_head("fpp_pop3", 8'h14, 3'b000); pop_head();
    expect_head("fpp_pop4", 8'h55, 3'b000); pop_head();
    check("fpp_drained_count", fifo_count, 0);

    // Reset in the middle of a 0x77 frame, with a frame already buffered.
    send_frame(8'h99, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    baud_div = 16'd1;
    @(posedge clk); #1 rx = 1'b0;
    repeat (16) @(posedge clk); #1 rx = 1'b1;
    repeat (16) @(posedge clk); #1 rx = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", frame_valid, 0);
    check("midrst_data", frame_data, 0);
    check("midrst_err", frame_err, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_overflow", overflow, 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(8'h12, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1);
    expect_head("post_rst", 8'h12, 3'b000);
    check("post_rst_count", fifo_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
